// File: rtl/mf_window.sv
// mf_window: sliding-window sample stager feeding the 20-tap matched filter.
// Keeps the last TAPS samples in a shift register and a run-time loadable
// coefficient bank; on every accepted sample it presents the whole window
// plus coefficients as a single-cycle push.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   pushin, sin          sample valid and signed sample
//   flush                clear window and fill count (coefficients kept)
//   cload, caddr, cdata  coefficient write strobe, index, value
//   pushout              window valid, one cycle per accepted push
//   dout00..dout19       window samples, dout00 newest, dout19 oldest
//   wout00..wout19       coefficient k on woutk
//
// Optional feature: define MF_WINDOW_PRIME_EN to suppress pushout until the
// window holds TAPS real samples after reset or flush.
module mf_window #(
  parameter int unsigned TAPS = 20,
  parameter int unsigned W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pushin,
  input  logic signed [W-1:0] sin,
  input  logic                flush,
  input  logic                cload,
  input  logic        [4:0]   caddr,
  input  logic signed [W-1:0] cdata,
  output logic                pushout,
  output logic signed [W-1:0] dout00, dout01, dout02, dout03, dout04,
                              dout05, dout06, dout07, dout08, dout09,
                              dout10, dout11, dout12, dout13, dout14,
                              dout15, dout16, dout17, dout18, dout19,
  output logic signed [W-1:0] wout00, wout01, wout02, wout03, wout04,
                              wout05, wout06, wout07, wout08, wout09,
                              wout10, wout11, wout12, wout13, wout14,
                              wout15, wout16, wout17, wout18, wout19
);

  localparam int unsigned FILL_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } state_t;

  state_t                 state, state_nx;
  logic [FILL_W-1:0]      fill, fill_nx;
  logic [TAPS-1:0][W-1:0] samp, samp_nx;
  logic [TAPS-1:0][W-1:0] coef;
  logic [TAPS-1:0][W-1:0] dout_q, wout_q;
  logic                   pushout_q;
  logic                   pushout_nx;

  // Window state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
      fill  <= '0;
      samp  <= '0;
    end else begin
      state <= state_nx;
      fill  <= fill_nx;
      samp  <= samp_nx;
    end
  end

  // Next window: flush is applied first, then a same-cycle sample is inserted
  always_comb begin
    state_nx   = state;
    fill_nx    = fill;
    samp_nx    = samp;
    pushout_nx = 1'b0;

    if (flush) begin
      state_nx = ST_EMPTY;
      fill_nx  = '0;
      samp_nx  = '0;
    end

    if (pushin) begin
      samp_nx = {samp_nx[TAPS-2:0], sin};
      unique case (state_nx)
        ST_EMPTY: begin
          fill_nx  = FILL_W'(1);
          state_nx = ST_FILLING;
        end
        ST_FILLING: begin
          fill_nx = fill_nx + FILL_W'(1);
          if (fill_nx == FILL_W'(TAPS)) state_nx = ST_FULL;
        end
        ST_FULL: begin
          fill_nx = FILL_W'(TAPS);
        end
        default: begin
          fill_nx  = '0;
          state_nx = ST_EMPTY;
        end
      endcase
`ifdef MF_WINDOW_PRIME_EN
      pushout_nx = (state_nx == ST_FULL);
`else
      pushout_nx = 1'b1;
`endif
    end
  end

  // Coefficient bank and output registers; wout captures coef before any same-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef      <= '0;
      dout_q    <= '0;
      wout_q    <= '0;
      pushout_q <= 1'b0;
    end else begin
      pushout_q <= pushout_nx;
      if (pushin) begin
        dout_q <= samp_nx;
        wout_q <= coef;
      end
      if (cload && (caddr < 5'(TAPS))) begin
        coef[caddr] <= cdata;
      end
    end
  end

  assign pushout = pushout_q;

  assign {dout19, dout18, dout17, dout16, dout15, dout14, dout13, dout12, dout11, dout10,
          dout09, dout08, dout07, dout06, dout05, dout04, dout03, dout02, dout01, dout00} = dout_q;

  assign {wout19, wout18, wout17, wout16, wout15, wout14, wout13, wout12, wout11, wout10,
          wout09, wout08, wout07, wout06, wout05, wout04, wout03, wout02, wout01, wout00} = wout_q;

endmodule

// File: tb/tb_mf_window.sv
// Self-checking bench for mf_window: queue-based reference model, per-cycle
// comparison of every output, directed scenarios with literal expectations,
// then a randomized phase.
module tb_mf_window;

`ifdef MF_WINDOW_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        pushin;
  logic [31:0] sin;
  logic        flush;
  logic        cload;
  logic [4:0]  caddr;
  logic [31:0] cdata;
  logic        pushout;
  logic [31:0] dout [20];
  logic [31:0] wout [20];

  int n_checks = 0;
  int n_pass   = 0;

  mf_window dut (
    .clk(clk), .reset(rst_n), .pushin(pushin), .sin(sin), .flush(flush),
    .cload(cload), .caddr(caddr), .cdata(cdata), .pushout(pushout),
    .dout00(dout[0]),  .dout01(dout[1]),  .dout02(dout[2]),  .dout03(dout[3]),
    .dout04(dout[4]),  .dout05(dout[5]),  .dout06(dout[6]),  .dout07(dout[7]),
    .dout08(dout[8]),  .dout09(dout[9]),  .dout10(dout[10]), .dout11(dout[11]),
    .dout12(dout[12]), .dout13(dout[13]), .dout14(dout[14]), .dout15(dout[15]),
    .dout16(dout[16]), .dout17(dout[17]), .dout18(dout[18]), .dout19(dout[19]),
    .wout00(wout[0]),  .wout01(wout[1]),  .wout02(wout[2]),  .wout03(wout[3]),
    .wout04(wout[4]),  .wout05(wout[5]),  .wout06(wout[6]),  .wout07(wout[7]),
    .wout08(wout[8]),  .wout09(wout[9]),  .wout10(wout[10]), .wout11(wout[11]),
    .wout12(wout[12]), .wout13(wout[13]), .wout14(wout[14]), .wout15(wout[15]),
    .wout16(wout[16]), .wout17(wout[17]), .wout18(wout[18]), .wout19(wout[19])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: window as a queue, newest sample at the front
  logic [31:0] win [$];
  logic [31:0] coef_m   [20];
  logic [31:0] exp_dout [20];
  logic [31:0] exp_wout [20];
  logic        exp_po;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.delete();
      exp_po = 1'b0;
      for (int k = 0; k < 20; k++) begin
        coef_m[k]   = '0;
        exp_dout[k] = '0;
        exp_wout[k] = '0;
      end
    end else begin
      exp_po = 1'b0;
      if (flush) win.delete();
      if (pushin) begin
        win.push_front(sin);
        if (win.size() > 20) void'(win.pop_back());
        exp_po = PRIME ? (win.size() == 20) : 1'b1;
        for (int k = 0; k < 20; k++) begin
          exp_dout[k] = (k < win.size()) ? win[k] : 32'd0;
          exp_wout[k] = coef_m[k];
        end
      end
      if (cload && caddr < 5'd20) coef_m[caddr] = cdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("pushout", {31'd0, pushout}, {31'd0, exp_po});
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("dout%02d", k), dout[k], exp_dout[k]);
      chk($sformatf("wout%02d", k), wout[k], exp_wout[k]);
    end
  end

  // Apply one cycle of inputs at the falling edge; return at the next falling edge
  task automatic step(input logic p, input logic [31:0] s, input logic f,
                      input logic cl, input logic [4:0] ca, input logic [31:0] cd);
    pushin = p; sin = s; flush = f; cload = cl; caddr = ca; cdata = cd;
    @(posedge clk);
    @(negedge clk);
    pushin = 1'b0; flush = 1'b0; cload = 1'b0;
  endtask

  task automatic push(input logic [31:0] s);
    step(1'b1, s, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b0; pushin = 1'b0; sin = '0; flush = 1'b0;
    cload = 1'b0; caddr = '0; cdata = '0;
    #1;
    chk("reset_pushout", {31'd0, pushout}, 32'd0);
    chk("reset_dout00", dout[0], 32'd0);
    chk("reset_wout19", wout[19], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample from empty
    push(32'd7);
    chk("first_pushout", {31'd0, pushout}, {31'd0, !PRIME});
    chk("first_dout00", dout[0], 32'd7);
    chk("first_dout01", dout[1], 32'd0);
    chk("first_wout00", wout[0], 32'd0);

    // Priming and wrap-around
    reset_pulse();
    for (int i = 1; i <= 25; i++) begin
      push(32'(i));
      if (i == 19) chk("prime19_pushout", {31'd0, pushout}, {31'd0, !PRIME});
      if (i == 20) begin
        chk("prime20_pushout", {31'd0, pushout}, 32'd1);
        chk("prime20_dout00", dout[0], 32'd20);
        chk("prime20_dout19", dout[19], 32'd1);
      end
    end
    chk("wrap_dout00", dout[0], 32'd25);
    chk("wrap_dout19", dout[19], 32'd6);
    chk("wrap_pushout", {31'd0, pushout}, 32'd1);

    // Coefficient load in the same cycle as a push, then an ignored address
    step(1'b1, 32'd99, 1'b0, 1'b1, 5'd3, 32'h100);
    chk("cload_same_wout03", wout[3], 32'd0);
    push(32'd100);
    chk("cload_next_wout03", wout[3], 32'h100);
    step(1'b0, 32'd0, 1'b0, 1'b1, 5'd25, 32'hdead_beef);
    push(32'd101);
    chk("cload_oob_wout03", wout[3], 32'h100);
    chk("cload_oob_wout19", wout[19], 32'd0);

    // Flush together with a push
    step(1'b1, 32'd5, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("flushpush_dout00", dout[0], 32'd5);
    chk("flushpush_dout01", dout[1], 32'd0);
    chk("flushpush_dout19", dout[19], 32'd0);
    chk("flushpush_wout03", wout[3], 32'h100);
    chk("flushpush_pushout", {31'd0, pushout}, {31'd0, !PRIME});
    for (int i = 1; i <= 19; i++) begin
      push(32'(100 + i));
      chk($sformatf("refill%0d_pushout", i), {31'd0, pushout},
          {31'd0, (!PRIME) || (i == 19)});
    end

    // Flush without a push: no pushout, outputs hold
    held = dout[0];
    step(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("flush_only_pushout", {31'd0, pushout}, 32'd0);
    chk("flush_only_hold", dout[0], held);
    push(32'd77);
    chk("after_flush_dout01", dout[1], 32'd0);

    // Asynchronous reset between edges during continuous pushes
    for (int i = 0; i < 5; i++) push(32'(200 + i));
    pushin = 1'b1; sin = 32'd300;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pushout", {31'd0, pushout}, 32'd0);
    chk("async_dout00", dout[0], 32'd0);
    chk("async_wout03", wout[3], 32'd0);
    @(negedge clk);
    pushin = 1'b0;
    rst_n = 1'b1;
    push(32'd42);
    chk("post_reset_dout00", dout[0], 32'd42);
    chk("post_reset_dout01", dout[1], 32'd0);
    chk("post_reset_pushout", {31'd0, pushout}, {31'd0, !PRIME});

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom(), $urandom_range(0, 19) == 0,
             $urandom_range(0, 4) == 0, 5'($urandom_range(0, 31)), $urandom());
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
